// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer: debounces one straight key and times presses/gaps into dot, dash and enter strobes.
// Optional word-gap stage (WGAP state, word_space strobe) is built only when WORD_GAP_EN is defined.
module morse_key_sequencer #(
   parameter int CNT_W        = 16,
   parameter int DEBOUNCE_CYC = 4,
   parameter int DASH_THRESH  = 300,
   parameter int LETTER_GAP   = 600,
   parameter int WORD_GAP     = 1400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_raw,
   input  logic       ctrl_en,
   output logic       btn_dot,
   output logic       btn_dash,
   output logic       btn_enter,
   output logic [2:0] sym_cnt,
   output logic       overflow,
   output logic       busy,
   output logic       word_space
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRESS = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
`ifdef WORD_GAP_EN
   localparam logic [1:0] S_WGAP  = 2'd3;
   localparam logic [CNT_W-1:0] WGAP_END = CNT_W'(WORD_GAP - 1);
`endif
   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(DASH_THRESH);
   localparam logic [CNT_W-1:0] LGAP_END = CNT_W'(LETTER_GAP - 1);

   if (DEBOUNCE_CYC < 1 || LETTER_GAP < 2 || WORD_GAP <= LETTER_GAP) begin : g_bad_cfg
      $error("morse_key_sequencer: inconsistent debounce/gap parameters");
   end

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic            sync1_q, sync2_q, key_db_q, key_prev_q;
   logic [DB_W-1:0] db_cnt_q;
   logic            db_rise_s, db_fall_s;
   logic [1:0]      state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d, timer_inc_s;
   logic [2:0]      sym_q, sym_d;
   logic            dot_q, dot_d, dash_q, dash_d, enter_q, enter_d, ovf_q, ovf_d, busy_q;
`ifdef WORD_GAP_EN
   logic            ws_q, ws_d;
`endif

   // Synchronize the raw key and accept a new level only after DEBOUNCE_CYC stable disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         key_db_q   <= 1'b0;
         key_prev_q <= 1'b0;
         db_cnt_q   <= {DB_W{1'b0}};
      end else begin
         sync1_q    <= key_raw;
         sync2_q    <= sync1_q;
         key_prev_q <= key_db_q;
         if (sync2_q == key_db_q) begin
            db_cnt_q <= {DB_W{1'b0}};
         end else if (db_cnt_q == DB_LAST) begin
            key_db_q <= sync2_q;
            db_cnt_q <= {DB_W{1'b0}};
         end else begin
            db_cnt_q <= db_cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Edges are taken against the previous debounced level, so a key already held when
   // ctrl_en rises never looks like a fresh press.
   assign db_rise_s   = key_db_q & ~key_prev_q;
   assign db_fall_s   = ~key_db_q & key_prev_q;
   assign timer_inc_s = sat_inc(timer_q);

   // Sequencer next-state: press/gap timing and strobe selection.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      sym_d   = sym_q;
      dot_d   = 1'b0;
      dash_d  = 1'b0;
      enter_d = 1'b0;
      ovf_d   = 1'b0;
`ifdef WORD_GAP_EN
      ws_d    = 1'b0;
`endif
      if (!ctrl_en) begin
         state_d = S_IDLE;
         timer_d = {CNT_W{1'b0}};
         sym_d   = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (db_rise_s) begin
                  state_d = S_PRESS;
                  timer_d = {CNT_W{1'b0}};
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_PRESS: begin
               // timer_inc_s on the release cycle equals the number of cycles key_db was high
               if (db_fall_s) begin
                  state_d = S_GAP;
                  timer_d = {CNT_W{1'b0}};
                  if (sym_q < 3'd5) begin
                     sym_d  = sym_q + 3'd1;
                     dash_d = (timer_inc_s >= DASH_MIN);
                     dot_d  = (timer_inc_s <  DASH_MIN);
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  timer_d = timer_inc_s;
               end
            end
            S_GAP: begin
               if (db_rise_s) begin
                  state_d = S_PRESS;
                  timer_d = {CNT_W{1'b0}};
               end else if (timer_q == LGAP_END) begin
                  enter_d = (sym_q != 3'd0);
                  sym_d   = 3'd0;
`ifdef WORD_GAP_EN
                  state_d = S_WGAP;
                  timer_d = timer_inc_s;
`else
                  state_d = S_IDLE;
                  timer_d = {CNT_W{1'b0}};
`endif
               end else begin
                  timer_d = timer_inc_s;
               end
            end
`ifdef WORD_GAP_EN
            S_WGAP: begin
               if (db_rise_s) begin
                  state_d = S_PRESS;
                  timer_d = {CNT_W{1'b0}};
               end else if (timer_q == WGAP_END) begin
                  ws_d    = 1'b1;
                  state_d = S_IDLE;
                  timer_d = {CNT_W{1'b0}};
               end else begin
                  timer_d = timer_inc_s;
               end
            end
`endif
            default: begin
               state_d = S_IDLE;
               timer_d = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Sequencer state and registered strobe outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= {CNT_W{1'b0}};
         sym_q   <= 3'd0;
         dot_q   <= 1'b0;
         dash_q  <= 1'b0;
         enter_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sym_q   <= sym_d;
         dot_q   <= dot_d;
         dash_q  <= dash_d;
         enter_q <= enter_d;
         ovf_q   <= ovf_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

`ifdef WORD_GAP_EN
   // Registered end-of-word strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ws_q <= 1'b0;
      end else begin
         ws_q <= ws_d;
      end
   end
   assign word_space = ws_q;
`else
   assign word_space = 1'b0;
`endif

   assign btn_dot   = dot_q;
   assign btn_dash  = dash_q;
   assign btn_enter = enter_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;
   assign sym_cnt   = sym_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Testbench for morse_key_sequencer: press/gap scenarios scored against an event-level timing model.
module tb_morse_key_sequencer;

   localparam int DB   = 4;
   localparam int DASH = 300;
   localparam int LG   = 600;
   localparam int WG   = 1400;
   localparam int DLY  = 2 + DB + 1;  // key_raw release to strobe, in clock edges
   localparam int K_DOT = 0, K_DASH = 1, K_ENTER = 2, K_OVF = 3, K_WS = 4;

   typedef struct packed {int cyc; int kind; int sym;} ev_t;

   logic       clk = 1'b0, rst = 1'b1, key_raw = 1'b0, ctrl_en = 1'b1;
   logic       btn_dot, btn_dash, btn_enter, overflow, busy, word_space;
   logic [2:0] sym_cnt;

   int   cyc = 0, n_checks = 0, n_fail = 0, b2b_viol = 0;
   logic prev_any = 1'b0;
   ev_t  exp_q[$], act_q[$];
   int   press_len[64], gap_len[64];

   morse_key_sequencer dut (
      .clk(clk), .rst(rst), .key_raw(key_raw), .ctrl_en(ctrl_en),
      .btn_dot(btn_dot), .btn_dash(btn_dash), .btn_enter(btn_enter),
      .sym_cnt(sym_cnt), .overflow(overflow), .busy(busy), .word_space(word_space)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic any;
      if (!rst) begin
         any = btn_dot | btn_dash | btn_enter | overflow | word_space;
         if (btn_dot)    act_q.push_back('{cyc, K_DOT,   int'(sym_cnt)});
         if (btn_dash)   act_q.push_back('{cyc, K_DASH,  int'(sym_cnt)});
         if (btn_enter)  act_q.push_back('{cyc, K_ENTER, int'(sym_cnt)});
         if (overflow)   act_q.push_back('{cyc, K_OVF,   int'(sym_cnt)});
         if (word_space) act_q.push_back('{cyc, K_WS,    int'(sym_cnt)});
         if (any && prev_any) b2b_viol++;
         prev_any = any;
      end else begin
         prev_any = 1'b0;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Event-level model: each release yields a symbol (or overflow past 5), a gap longer
   // than LG ends the letter, and (with WORD_GAP_EN) a gap longer than WG ends the word.
   task automatic add_expected(input int start, input int n);
      int t, r, sym;
      t = start;
      sym = 0;
      for (int i = 0; i < n; i++) begin
         r = t + press_len[i];
         if (sym < 5) begin
            sym++;
            exp_q.push_back('{r + DLY, (press_len[i] >= DASH) ? K_DASH : K_DOT, sym});
         end else begin
            exp_q.push_back('{r + DLY, K_OVF, 5});
         end
         if (gap_len[i] > LG) begin
            exp_q.push_back('{r + DLY + LG, K_ENTER, 0});
            sym = 0;
`ifdef WORD_GAP_EN
            if (gap_len[i] > WG) exp_q.push_back('{r + DLY + WG, K_WS, 0});
`endif
         end
         t = r + gap_len[i];
      end
   endtask

   task automatic play(input int n);
      exp_q.delete();
      act_q.delete();
      add_expected(cyc, n);
      for (int i = 0; i < n; i++) begin
         key_raw = 1'b1;
         wait_cyc(press_len[i]);
         key_raw = 1'b0;
         wait_cyc(gap_len[i]);
      end
   endtask

   task automatic test_reset;
      n_checks++;
      if ({btn_dot, btn_dash, btn_enter, overflow, busy, word_space, sym_cnt} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_in: outputs %b, expected all 0", {btn_dot, btn_dash, btn_enter, overflow, busy, word_space, sym_cnt});
      end
      rst = 1'b0;
      wait_cyc(5);
      n_checks++;
      if ({btn_dot, btn_dash, btn_enter, overflow, busy, word_space, sym_cnt} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_out: outputs %b, expected all 0", {btn_dot, btn_dash, btn_enter, overflow, busy, word_space, sym_cnt});
      end
      act_q.delete();
      key_raw = 1'b1;
      wait_cyc(80);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_press_busy: busy=%b, expected 1", busy);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({btn_dot, btn_dash, btn_enter, overflow, busy, word_space, sym_cnt} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_midpress: outputs %b, expected all 0", {btn_dot, btn_dash, btn_enter, overflow, busy, word_space, sym_cnt});
      end
      wait_cyc(70);
      key_raw = 1'b0;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(800);
      n_checks++;
      if (act_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_quiet: %0d strobes busy=%b, expected 0 strobes busy=0", act_q.size(), busy);
      end
   endtask

   task automatic test_dot_dash;
      press_len[0] = 100; gap_len[0] = 700;
      press_len[1] = 400; gap_len[1] = 700;
      press_len[2] = 300; gap_len[2] = 700;
      press_len[3] = 299; gap_len[3] = 1500;
      play(4);
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL dot_dash_count: got %0d events, expected %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         n_checks++;
         if (act_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL dot_dash_ev%0d: got cyc=%0d kind=%0d sym=%0d, expected cyc=%0d kind=%0d sym=%0d",
                     i, act_q[i].cyc, act_q[i].kind, act_q[i].sym, exp_q[i].cyc, exp_q[i].kind, exp_q[i].sym);
         end
      end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 6; i++) begin
         press_len[i] = 100;
         gap_len[i]   = (i == 5) ? 1500 : 50;
      end
      play(6);
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL overflow_count: got %0d events, expected %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         n_checks++;
         if (act_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL overflow_ev%0d: got cyc=%0d kind=%0d sym=%0d, expected cyc=%0d kind=%0d sym=%0d",
                     i, act_q[i].cyc, act_q[i].kind, act_q[i].sym, exp_q[i].cyc, exp_q[i].kind, exp_q[i].sym);
         end
      end
      n_checks++;
      if (sym_cnt !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_end: sym_cnt=%0d busy=%b, expected 0/0", sym_cnt, busy);
      end
   endtask

   task automatic test_glitch_abort;
      act_q.delete();
      key_raw = 1'b1;
      wait_cyc(2);
      key_raw = 1'b0;
      wait_cyc(30);
      n_checks++;
      if (act_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch: %0d strobes busy=%b, expected 0 strobes busy=0", act_q.size(), busy);
      end
      key_raw = 1'b1;
      wait_cyc(50);
      ctrl_en = 1'b0;
      wait_cyc(20);
      n_checks++;
      if (busy !== 1'b0 || sym_cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b sym_cnt=%0d, expected 0/0", busy, sym_cnt);
      end
      ctrl_en = 1'b1;
      wait_cyc(30);
      key_raw = 1'b0;
      wait_cyc(800);
      n_checks++;
      if (act_q.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_quiet: %0d strobes busy=%b, expected 0 strobes busy=0", act_q.size(), busy);
      end
   endtask

   task automatic test_word_gap;
      press_len[0] = 100; gap_len[0] = 1500;
      play(1);
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL word_gap_count: got %0d events, expected %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         n_checks++;
         if (act_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL word_gap_ev%0d: got cyc=%0d kind=%0d sym=%0d, expected cyc=%0d kind=%0d sym=%0d",
                     i, act_q[i].cyc, act_q[i].kind, act_q[i].sym, exp_q[i].cyc, exp_q[i].kind, exp_q[i].sym);
         end
      end
   endtask

   task automatic test_random;
      int n, k;
      n = 0;
      for (int l = 0; l < 5; l++) begin
         k = $urandom_range(1, 7);
         for (int j = 0; j < k; j++) begin
            press_len[n] = $urandom_range(10, 500);
            gap_len[n]   = (j == k - 1) ? $urandom_range(650, 700) : $urandom_range(20, 300);
            n++;
         end
      end
      gap_len[n-1] = 1500;
      play(n);
      n_checks++;
      if (act_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_count: got %0d events, expected %0d", act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
         n_checks++;
         if (act_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random_ev%0d: got cyc=%0d kind=%0d sym=%0d, expected cyc=%0d kind=%0d sym=%0d",
                     i, act_q[i].cyc, act_q[i].kind, act_q[i].sym, exp_q[i].cyc, exp_q[i].kind, exp_q[i].sym);
         end
      end
      n_checks++;
      if (busy !== 1'b0 || sym_cnt !== 3'd0) begin
         n_fail++;
         $display("FAIL random_end: busy=%b sym_cnt=%0d, expected 0/0", busy, sym_cnt);
      end
   endtask

   task automatic test_back_to_back;
      n_checks++;
      if (b2b_viol != 0) begin
         n_fail++;
         $display("FAIL back_to_back: %0d adjacent-cycle strobes, expected 0", b2b_viol);
      end
   endtask

   initial begin
      wait_cyc(3);
      test_reset();
      test_dot_dash();
      test_overflow();
      test_glitch_abort();
      test_word_gap();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
